// File: rtl/als_sample_ctrl.sv
// -----------------------------------------------------------------------------
// als_sample_ctrl
//
// Paces reads from an ambient-light-sensor SPI reader. A free-running period
// counter offers a read opportunity once every PERIOD_CYCLES clocks. Each
// opportunity issues a single-cycle read strobe and then waits a bounded time
// for the reader's answer. Answered samples are averaged over windows of
// 2^AVG_LOG2 samples. Unanswered requests raise a sticky timeout flag.
//
// Optional feature macro: ALS_MINMAX_EN
//   defined   : per-window minimum/maximum tracking drives min_o/max_o
//   undefined : no tracker logic; min_o and max_o are constant 0
//
// Parameters
//   PERIOD_CYCLES  clk_i cycles between read-request opportunities (>= 4)
//   TIMEOUT_CYCLES maximum clk_i cycles from rd_req_o to valid_i
//   AVG_LOG2       log2 of samples per averaging window (1..6)
//
// Ports
//   clk_i        in   system clock, rising edge
//   rst_i        in   asynchronous active-high reset
//   rd_req_o     out  single-cycle read strobe to the ALS SPI reader
//   valid_i      in   single-cycle strobe qualifying value_i
//   value_i      in   [7:0] unsigned ALS sample
//   clear_i      in   synchronous clear of window state and timeout flag
//   avg_o        out  [7:0] average of last completed window
//   avg_valid_o  out  one-cycle pulse when avg_o/min_o/max_o update
//   min_o        out  [7:0] minimum sample of last completed window
//   max_o        out  [7:0] maximum sample of last completed window
//   timeout_o    out  sticky: a request got no valid_i in time
// -----------------------------------------------------------------------------
module als_sample_ctrl #(
    parameter int PERIOD_CYCLES  = 100000,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int AVG_LOG2       = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       rd_req_o,
    input  logic       valid_i,
    input  logic [7:0] value_i,
    input  logic       clear_i,
    output logic [7:0] avg_o,
    output logic       avg_valid_o,
    output logic [7:0] min_o,
    output logic [7:0] max_o,
    output logic       timeout_o
);

    localparam int DATA_W = 8;
    localparam int ACC_W  = DATA_W + AVG_LOG2;
    localparam int PCNT_W = $clog2(PERIOD_CYCLES);
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [PCNT_W-1:0]   PCNT_LAST  = PCNT_W'(PERIOD_CYCLES - 1);
    localparam logic [TCNT_W-1:0]   TCNT_LIMIT = TCNT_W'(TIMEOUT_CYCLES);
    localparam logic [AVG_LOG2-1:0] CNT_FULL   = '1;

    // Window average: plain truncation of the full-window sum. The sum is
    // DATA_W + AVG_LOG2 bits wide, so the shifted result always fits DATA_W.
    function automatic logic [DATA_W-1:0] window_avg(input logic [ACC_W-1:0] sum);
        return DATA_W'(sum >> AVG_LOG2);
    endfunction

    logic [PCNT_W-1:0]   pcnt;
    logic [TCNT_W-1:0]   tcnt;
    logic [1:0]          state;
    logic [ACC_W-1:0]    acc;
    logic [AVG_LOG2-1:0] cnt;

    logic             period_exp;
    logic             sample_take;
    logic             window_done;
    logic [ACC_W-1:0] sum_next;

    assign period_exp  = (pcnt == PCNT_LAST);
    // clear_i has priority over a coincident sample
    assign sample_take = (state == ST_WAIT) && valid_i && !clear_i;
    assign window_done = sample_take && (cnt == CNT_FULL);
    assign sum_next    = acc + ACC_W'(value_i);

    // Period counter: free-running, independent of clear_i
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcnt <= '0;
        end else if (period_exp) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PCNT_W'(1);
        end
    end

    // Request FSM. rd_req_o is registered out of the REQ state, so the strobe
    // is seen during the first WAIT cycle, with the timeout counter at 0.
    // An expiry seen outside IDLE is simply dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            rd_req_o  <= 1'b0;
            tcnt      <= '0;
            timeout_o <= 1'b0;
        end else begin
            rd_req_o <= 1'b0;
            if (clear_i) begin
                state     <= ST_IDLE;
                tcnt      <= '0;
                timeout_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (period_exp) begin
                            state <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        rd_req_o <= 1'b1;
                        tcnt     <= '0;
                        state    <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (valid_i) begin
                            state <= ST_IDLE;
                        end else if (tcnt == TCNT_LIMIT) begin
                            state     <= ST_IDLE;
                            timeout_o <= 1'b1;
                        end else begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Window accumulator and average output
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc         <= '0;
            cnt         <= '0;
            avg_o       <= '0;
            avg_valid_o <= 1'b0;
        end else begin
            avg_valid_o <= 1'b0;
            if (clear_i) begin
                acc <= '0;
                cnt <= '0;
            end else if (window_done) begin
                avg_o       <= window_avg(sum_next);
                avg_valid_o <= 1'b1;
                acc         <= '0;
                cnt         <= '0;
            end else if (sample_take) begin
                acc <= sum_next;
                cnt <= cnt + AVG_LOG2'(1);
            end
        end
    end

`ifdef ALS_MINMAX_EN
    logic [DATA_W-1:0] min_trk;
    logic [DATA_W-1:0] max_trk;
    logic [DATA_W-1:0] min_q;
    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] min_next;
    logic [DATA_W-1:0] max_next;

    assign min_next = (value_i < min_trk) ? value_i : min_trk;
    assign max_next = (value_i > max_trk) ? value_i : max_trk;

    // Trackers restart empty (min at full scale, max at zero) every window
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            min_trk <= '1;
            max_trk <= '0;
            min_q   <= '0;
            max_q   <= '0;
        end else if (clear_i) begin
            min_trk <= '1;
            max_trk <= '0;
        end else if (window_done) begin
            min_q   <= min_next;
            max_q   <= max_next;
            min_trk <= '1;
            max_trk <= '0;
        end else if (sample_take) begin
            min_trk <= min_next;
            max_trk <= max_next;
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;
`else
    assign min_o = '0;
    assign max_o = '0;
`endif

endmodule

// File: doc/als_sample_ctrl.md
ALS_SAMPLE_CTRL -- requirements
Module: als_sample_ctrl

Interface
REQ-001 SHALL have parameter PERIOD_CYCLES, default 100000, clk_i cycles between read-request opportunities (>=4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum clk_i cycles from rd_req_o to valid_i.
REQ-003 SHALL have parameter AVG_LOG2, default 3, log2 of samples per averaging window (1..6).
REQ-004 SHALL have port clk_i  input  1  system clock; all logic on posedge clk_i.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rd_req_o  output  1  single-cycle read strobe to the ALS SPI reader.
REQ-007 SHALL have port valid_i  input  1  single-cycle strobe from the reader qualifying value_i.
REQ-008 SHALL have port value_i  input  8  ALS sample, unsigned.
REQ-009 SHALL have port clear_i  input  1  synchronous clear of window and error flag.
REQ-010 SHALL have port avg_o  output  8  last completed window average.
REQ-011 SHALL have port avg_valid_o  output  1  one-cycle pulse when avg_o/min_o/max_o update.
REQ-012 SHALL have port min_o  output  8  minimum sample of last completed window.
REQ-013 SHALL have port max_o  output  8  maximum sample of last completed window.
REQ-014 SHALL have port timeout_o  output  1  sticky flag: a request received no valid_i in time.

Function
REQ-015 SHALL run a free-running period counter 0..PERIOD_CYCLES-1, wrapping to 0; expiry = counter at PERIOD_CYCLES-1.
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT; reset state IDLE.
REQ-017 IDLE->REQ on period expiry; expiry while not IDLE is skipped, no request queued.
REQ-018 REQ: rd_req_o high for exactly one cycle, then WAIT with timeout counter cleared.
REQ-019 WAIT->IDLE on valid_i: value_i added to accumulator (width 8+AVG_LOG2), sample count incremented.
REQ-020 WAIT->IDLE when timeout counter reaches TIMEOUT_CYCLES without valid_i: timeout_o set, no sample taken.
REQ-021 valid_i outside WAIT SHALL be ignored.
REQ-022 When accepted sample makes count = 2^AVG_LOG2: next cycle avg_o = (accumulator incl. that sample) >> AVG_LOG2 (truncate), min_o/max_o latched, avg_valid_o high one cycle; accumulator, count, min/max trackers restart empty.
REQ-023 Accumulator SHALL not overflow: 2^AVG_LOG2 samples of 255 yield avg_o = 255.
REQ-024 clear_i SHALL zero accumulator, count, trackers, timeout_o next cycle; avg_o/min_o/max_o keep last values; FSM -> IDLE.
REQ-025 clear_i and valid_i in same cycle: clear wins, sample discarded.
REQ-026 clear_i and timeout expiry in same cycle: timeout_o ends 0.
REQ-027 Period counter SHALL be unaffected by clear_i.

Reset
REQ-028 rst_i SHALL asynchronously force: FSM IDLE, period/timeout counters 0, accumulator/count 0, rd_req_o 0, avg_valid_o 0, avg_o 0, min_o 0, max_o 0, timeout_o 0.
REQ-029 Reset mid-WAIT SHALL abandon the request; a valid_i arriving after release in IDLE is ignored.
REQ-030 First rd_req_o after release SHALL occur PERIOD_CYCLES+1 cycles after the first rising edge with rst_i low.

Configuration
REQ-031 Macro ALS_MINMAX_EN defined: min/max tracking per REQ-022 (trackers start min=255, max=0 per window).
REQ-032 Macro ALS_MINMAX_EN undefined: no tracker logic; min_o and max_o constant 0; all else unchanged.

Verification (bench: PERIOD_CYCLES=16, TIMEOUT_CYCLES=8, AVG_LOG2=2, ALS_MINMAX_EN defined unless stated)
REQ-033 Four requests answered with 10, 20, 30, 41 -> one avg_valid_o pulse, avg_o=25, min_o=10, max_o=41.
REQ-034 Four requests answered with 255 each -> avg_o=255, min_o=max_o=255.
REQ-035 Request with no valid_i -> timeout_o=1 9 cycles after rd_req_o, FSM IDLE; window still needs 4 samples.
REQ-036 Two samples accepted, then clear_i coincident with third valid_i -> sample dropped, timeout_o=0, next four samples 4,4,8,8 -> avg_o=6.
REQ-037 rst_i pulsed during WAIT, then valid_i -> all outputs 0, no accumulation, next rd_req_o 17 cycles after release.
REQ-038 ALS_MINMAX_EN undefined, samples 10,20,30,41 -> avg_o=25, min_o=max_o=0.
